horner_poly_eval: RTL

//  Parametrised polynomial evaluator: y = a[DEG]*x^DEG + ... + a[1]*x + a[0], modulo 2^W.

---
 rtl/poly_pkg.sv | 26 ++
 rtl/poly_alu.sv | 34 +++
 rtl/horner_poly_eval.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/poly_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | poly_pkg : shared types and helpers for the Horner evaluator       |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
package poly_pkg;

   localparam int DEG_MAX = 15;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      MUL  = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic ALU_ADD = 1'b0;
   localparam logic ALU_MUL = 1'b1;

   // Bits needed to hold n distinct values (at least 1).
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/poly_alu.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | poly_alu : shared add/multiply unit with W-bit overflow detection  |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module poly_alu
   import poly_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y,
   output logic         ovf
);

   logic [2*W-1:0] prod;
   logic [W:0]     sum;

   assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
   assign sum  = {1'b0, a} + {1'b0, b};

   always_comb begin
      y   = sum[W-1:0];
      ovf = sum[W];
      if (op == ALU_MUL) begin
         y   = prod[W-1:0];
         ovf = |prod[2*W-1:W];
      end
   end

endmodule
`default_nettype wire

// File: rtl/horner_poly_eval.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | horner_poly_eval : streamed polynomial evaluator (Horner, mod 2^W) |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module horner_poly_eval
   import poly_pkg::*;
#(
   parameter int W   = 8,
   parameter int DEG = 2
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         abort,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] data_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         overflow,
   output logic         busy
);

   localparam int LW = cnt_w(DEG + 2);
   localparam int KW = cnt_w(DEG + 1);
   localparam logic [LW-1:0] LD_X  = LW'(DEG + 1);
   localparam logic [KW-1:0] K_TOP = KW'(DEG - 1);

   state_t         state_q, state_d;
   logic [LW-1:0]  ld_cnt_q, ld_cnt_d;
   logic [KW-1:0]  k_q, k_d;
   logic [W-1:0]   x_q, x_d;
   logic [W-1:0]   acc_q, acc_d;
   logic           ovf_q, ovf_d;
   logic [W-1:0]   result_q, result_d;
   logic           overflow_q, overflow_d;
   logic [W-1:0]   coef_q [0:DEG];
   logic [W-1:0]   coef_d [0:DEG];
   logic           shift_en;

   logic           alu_op;
   logic [W-1:0]   alu_b;
   logic [W-1:0]   alu_y;
   logic           alu_ovf;

   poly_alu #(.W(W)) u_alu (
      .op  (alu_op),
      .a   (acc_q),
      .b   (alu_b),
      .y   (alu_y),
      .ovf (alu_ovf)
   );

   // Coefficients shift in from index 0, so after DEG+1 words coef[j] holds a[j].
   for (genvar j = 0; j <= DEG; j++) begin : g_coef
      if (j == 0) begin : g_head
         assign coef_d[j] = shift_en ? data_in : coef_q[j];
      end else begin : g_body
         assign coef_d[j] = shift_en ? coef_q[j-1] : coef_q[j];
      end

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) coef_q[j] <= '0;
         else         coef_q[j] <= coef_d[j];
      end
   end

   always_comb begin
      state_d    = state_q;
      ld_cnt_d   = ld_cnt_q;
      k_d        = k_q;
      x_d        = x_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      shift_en   = 1'b0;
      alu_op     = ALU_ADD;
      alu_b      = coef_q[k_q];

      if (abort) begin
         state_d  = LOAD;
         ld_cnt_d = '0;
      end else begin
         case (state_q)
            LOAD: begin
               if (in_valid) begin
                  if (ld_cnt_q == LD_X) begin
                     x_d      = data_in;
                     acc_d    = coef_q[DEG];
                     k_d      = K_TOP;
                     ovf_d    = 1'b0;
                     ld_cnt_d = '0;
                     state_d  = MUL;
                  end else begin
                     shift_en = 1'b1;
                     ld_cnt_d = ld_cnt_q + 1'b1;
                  end
               end
            end
            MUL: begin
               alu_op  = ALU_MUL;
               alu_b   = x_q;
               acc_d   = alu_y;
               ovf_d   = ovf_q | alu_ovf;
               state_d = ADD;
            end
            ADD: begin
               acc_d = alu_y;
               ovf_d = ovf_q | alu_ovf;
               if (k_q == '0) begin
                  result_d   = alu_y;
                  overflow_d = ovf_q | alu_ovf;
                  state_d    = DONE;
               end else begin
                  k_d     = k_q - 1'b1;
                  state_d = MUL;
               end
            end
            DONE: begin
               if (out_ready) state_d = LOAD;
            end
            default: state_d = LOAD;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= LOAD;
         ld_cnt_q   <= '0;
         k_q        <= '0;
         x_q        <= '0;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ld_cnt_q   <= ld_cnt_d;
         k_q        <= k_d;
         x_q        <= x_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
      end
   end

   assign in_ready  = (state_q == LOAD);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == MUL) || (state_q == ADD);
   assign result    = result_q;
   assign overflow  = overflow_q;

endmodule
`default_nettype wire
